// File: rtl/bind_chk_pkg.sv
// Shared types and helpers for the bindable multi-channel checker.
// Holds the FSM state encoding, width helper and popcount.
package bind_chk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } chk_state_t;

  // Widest mismatch vector popcount accepts; channels beyond are dropped.
  localparam int POP_MAX = 64;

  function automatic int clog2m1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int popcount(input logic [POP_MAX-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < POP_MAX; i++) begin
      c += int'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/bind_chk_lane.sv
// One monitored channel: masked compare against its expected value.
// A lane whose mask is all zeros can never report a mismatch.
module bind_chk_lane #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] EXP  = '0,
  parameter logic [WIDTH-1:0] MASK = '1
) (
  input  logic [WIDTH-1:0] i_p,
  output logic             o_mis
);

  logic [WIDTH-1:0] w_diff;

  assign w_diff = (i_p ^ EXP) & MASK;
  assign o_mis  = |w_diff;

endmodule

// File: rtl/bind_multi_checker.sv
// Bindable run-time checker: settle, sample a window, compare all channels,
// and keep registered pass/fail, error count and first-failure location.
module bind_multi_checker
  import bind_chk_pkg::*;
#(
  parameter int                     NCHAN         = 3,
  parameter int                     WIDTH         = 8,
  parameter logic [NCHAN*WIDTH-1:0] EXP_VALS      = '0,
  parameter logic [NCHAN*WIDTH-1:0] CHK_MASK      = '1,
  parameter int                     SETTLE_CYCLES = 1,
  parameter int                     CHECK_CYCLES  = 4,
  parameter bit                     STOP_ON_FAIL  = 1'b0,
  localparam int CW  = $clog2(NCHAN*CHECK_CYCLES+1),
  localparam int FCW = clog2m1(NCHAN),
  localparam int FYW = clog2m1(CHECK_CYCLES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NCHAN*WIDTH-1:0] p,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CW-1:0]          err_count,
  output logic [FCW-1:0]         first_chan,
  output logic [FYW-1:0]         first_cyc
);

  localparam int SW      = clog2m1(SETTLE_CYCLES + 1);
  localparam int ERR_MAX = (2 ** CW) - 1;

  chk_state_t     r_state;
  logic [SW-1:0]  r_scnt;
  logic [FYW-1:0] r_cyc;
  logic           r_busy;
  logic           r_done;
  logic           r_pass;
  logic [CW-1:0]  r_err;
  logic [FCW-1:0] r_fc;
  logic [FYW-1:0] r_fy;

  logic [NCHAN-1:0] w_mis;
  logic             w_any;
  logic [FCW-1:0]   w_lo;
  int               w_sum;
  logic [CW-1:0]    w_err_nx;
  logic             w_last;
  logic             w_stop;
  logic             w_set_end;
  logic             w_new_hit;

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_lane
    bind_chk_lane #(
      .WIDTH (WIDTH),
      .EXP   (EXP_VALS[gi*WIDTH +: WIDTH]),
      .MASK  (CHK_MASK[gi*WIDTH +: WIDTH])
    ) u_lane (
      .i_p   (p[gi*WIDTH +: WIDTH]),
      .o_mis (w_mis[gi])
    );
  end

  // Lowest mismatching channel wins: scan downward so index 0 lands last.
  always_comb begin
    w_lo = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (w_mis[i]) w_lo = FCW'(i);
    end
  end

  always_comb begin
    w_sum    = int'(r_err) + popcount(POP_MAX'(w_mis));
    w_err_nx = (w_sum > ERR_MAX) ? CW'(ERR_MAX) : CW'(w_sum);
  end

  assign w_any     = |w_mis;
  assign w_last    = (int'(r_cyc) == CHECK_CYCLES - 1);
  assign w_stop    = STOP_ON_FAIL && w_any;
  assign w_set_end = (int'(r_scnt) >= SETTLE_CYCLES - 1);
  // A zero count means nothing has mismatched yet in this window.
  assign w_new_hit = w_any && (r_err == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_cyc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fc    <= '0;
      r_fy    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_scnt <= '0;
          r_cyc  <= '0;
          if (en) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fc    <= '0;
            r_fy    <= '0;
            r_state <= (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!en) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_set_end) begin
            r_scnt  <= '0;
            r_state <= S_CHECK;
          end else begin
            r_scnt <= r_scnt + SW'(1);
          end
        end
        S_CHECK: begin
          // A final or failing sample completes even if en drops with it.
          if (w_last || w_stop) begin
            r_err   <= w_err_nx;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nx == '0);
            r_state <= S_DONE;
            if (w_new_hit) begin
              r_fc <= w_lo;
              r_fy <= r_cyc;
            end
          end else if (!en) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_err <= w_err_nx;
            r_cyc <= r_cyc + FYW'(1);
            if (w_new_hit) begin
              r_fc <= w_lo;
              r_fy <= r_cyc;
            end
          end
        end
        S_DONE: begin
          if (!en) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_chan = r_fc;
  assign first_cyc  = r_fy;

endmodule

// File: tb/tb_bind_multi_checker.sv
// Bench for bind_multi_checker: random windows against a window-level model,
// plus directed cases with hand-computed results.
module tb_bind_multi_checker;

  localparam int          S    = 1;
  localparam int          C    = 4;
  localparam logic [23:0] EXPV = 24'h060504;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        en_ab = 1'b0;
  logic [23:0] p_ab  = '0;
  logic        a_busy, a_done, a_pass;
  logic [3:0]  a_err;
  logic [1:0]  a_fc, a_fy;
  logic        b_busy, b_done, b_pass;
  logic [3:0]  b_err;
  logic [1:0]  b_fc, b_fy;

  logic        en_c = 1'b0;
  logic [23:0] p_c  = '0;
  logic        c_busy, c_done, c_pass;
  logic [3:0]  c_err;
  logic [1:0]  c_fc, c_fy;

  logic        en_d = 1'b0;
  logic [7:0]  p_d  = '0;
  logic        d_busy, d_done, d_pass;
  logic        d_err, d_fc, d_fy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit busy;
    bit done;
    bit res;
    int err;
    bit pass;
    int fc;
    int fy;
  } exp_t;

  exp_t xa, xb;
  bit   chk_on = 1'b0;
  logic [23:0] pk [16];
  logic [23:0] ev;

  always #5 clk = ~clk;

  bind_multi_checker #(
    .NCHAN(3), .WIDTH(8), .EXP_VALS(EXPV), .CHK_MASK(24'hFFFFFF),
    .SETTLE_CYCLES(S), .CHECK_CYCLES(C), .STOP_ON_FAIL(1'b0)
  ) u_a (
    .clk(clk), .rst(rst), .en(en_ab), .p(p_ab),
    .busy(a_busy), .done(a_done), .pass(a_pass),
    .err_count(a_err), .first_chan(a_fc), .first_cyc(a_fy)
  );

  bind_multi_checker #(
    .NCHAN(3), .WIDTH(8), .EXP_VALS(EXPV), .CHK_MASK(24'hFFFFFF),
    .SETTLE_CYCLES(S), .CHECK_CYCLES(C), .STOP_ON_FAIL(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .en(en_ab), .p(p_ab),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .first_chan(b_fc), .first_cyc(b_fy)
  );

  bind_multi_checker #(
    .NCHAN(3), .WIDTH(8), .EXP_VALS(EXPV), .CHK_MASK(24'hFFFFF0),
    .SETTLE_CYCLES(1), .CHECK_CYCLES(4), .STOP_ON_FAIL(1'b0)
  ) u_c (
    .clk(clk), .rst(rst), .en(en_c), .p(p_c),
    .busy(c_busy), .done(c_done), .pass(c_pass),
    .err_count(c_err), .first_chan(c_fc), .first_cyc(c_fy)
  );

  bind_multi_checker #(
    .NCHAN(1), .WIDTH(8), .EXP_VALS(8'h04), .CHK_MASK(8'hFF),
    .SETTLE_CYCLES(0), .CHECK_CYCLES(1), .STOP_ON_FAIL(1'b0)
  ) u_d (
    .clk(clk), .rst(rst), .en(en_d), .p(p_d),
    .busy(d_busy), .done(d_done), .pass(d_pass),
    .err_count(d_err), .first_chan(d_fc), .first_cyc(d_fy)
  );

  task automatic cmp(input string n, input int act, input int e);
    total++;
    if (act != e) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", n, act, e);
    end
  endtask

  function automatic exp_t mk(input int k, input int kab, input int de,
                              input int e, input int fc, input int fy);
    exp_t x;
    if (k < kab) begin
      x.busy = (k < de);
      x.done = (k >= de);
    end else begin
      x.busy = 1'b0;
      x.done = (de <= kab);
    end
    x.res  = x.done;
    x.err  = e;
    x.pass = (e == 0);
    x.fc   = fc;
    x.fy   = fy;
    return x;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("a_busy", int'(a_busy), int'(xa.busy));
      cmp("a_done", int'(a_done), int'(xa.done));
      cmp("b_busy", int'(b_busy), int'(xb.busy));
      cmp("b_done", int'(b_done), int'(xb.done));
      if (xa.res) begin
        cmp("a_err",  int'(a_err),  xa.err);
        cmp("a_pass", int'(a_pass), int'(xa.pass));
        cmp("a_fc",   int'(a_fc),   xa.fc);
        cmp("a_fy",   int'(a_fy),   xa.fy);
      end
      if (xb.res) begin
        cmp("b_err",  int'(b_err),  xb.err);
        cmp("b_pass", int'(b_pass), int'(xb.pass));
        cmp("b_fc",   int'(b_fc),   xb.fc);
        cmp("b_fy",   int'(b_fy),   xb.fy);
      end
    end
  end

  // Start a window at the next edge, hold en for kab edges, with pk[k]
  // applied before edge k; expected results come from the sampled window.
  task automatic run_ab(input int kab);
    int cnt [C];
    int ea, eb, fc, fy, jstop;
    bit hit;
    logic [23:0] v;
    ea = 0; eb = 0; fc = 0; fy = 0; hit = 1'b0;
    for (int j = 0; j < C; j++) begin
      v = pk[S+1+j];
      cnt[j] = 0;
      for (int i = 0; i < 3; i++) begin
        if (v[i*8 +: 8] != ev[i*8 +: 8]) begin
          cnt[j]++;
          if (!hit) begin
            hit = 1'b1;
            fc  = i;
            fy  = j;
          end
        end
      end
      ea += cnt[j];
    end
    jstop = hit ? fy : C - 1;
    for (int j = 0; j <= jstop; j++) eb += cnt[j];
    for (int k = 0; k <= kab + 2; k++) begin
      en_ab = (k < kab);
      p_ab  = pk[k];
      @(posedge clk);
      #1;
      xa = mk(k, kab, S + C, ea, fc, fy);
      xb = mk(k, kab, S + 1 + jstop, eb, fc, fy);
      chk_on = 1'b1;
    end
    en_ab = 1'b0;
    @(posedge clk);
    #1;
    chk_on = 1'b0;
  endtask

  task automatic fill(input logic [23:0] v);
    for (int k = 0; k < 16; k++) pk[k] = v;
  endtask

  initial begin
    ev = EXPV;
    #12;
    cmp("rst_a_busy", int'(a_busy), 0);
    cmp("rst_a_done", int'(a_done), 0);
    cmp("rst_a_pass", int'(a_pass), 0);
    cmp("rst_a_err",  int'(a_err),  0);
    cmp("rst_a_fc",   int'(a_fc),   0);
    cmp("rst_a_fy",   int'(a_fy),   0);
    cmp("rst_d_done", int'(d_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    fill(ev);
    run_ab(8);
    cmp("t1_done", int'(a_done), 1);
    cmp("t1_pass", int'(a_pass), 1);
    cmp("t1_err",  int'(a_err),  0);

    fill(ev);
    for (int k = 4; k < 16; k++) pk[k] = 24'h060704;
    run_ab(7);
    cmp("t2_err",   int'(a_err),  2);
    cmp("t2_fc",    int'(a_fc),   1);
    cmp("t2_fy",    int'(a_fy),   2);
    cmp("t2_pass",  int'(a_pass), 0);
    cmp("t2_b_err", int'(b_err),  1);

    rst = 1'b1;
    #1;
    cmp("rst2_err",  int'(a_err),  0);
    cmp("rst2_fc",   int'(a_fc),   0);
    cmp("rst2_fy",   int'(a_fy),   0);
    cmp("rst2_done", int'(a_done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    fill(ev);
    pk[2] = 24'h070503;
    run_ab(6);
    cmp("t3_b_done", int'(b_done), 1);
    cmp("t3_b_err",  int'(b_err),  2);
    cmp("t3_b_fc",   int'(b_fc),   0);
    cmp("t3_b_fy",   int'(b_fy),   0);
    cmp("t3_a_err",  int'(a_err),  2);

    fill(24'h060704);
    run_ab(3);
    cmp("ab_a_done", int'(a_done), 0);

    en_ab = 1'b1;
    p_ab  = ev;
    @(posedge clk);
    #1;
    cmp("rs_busy", int'(a_busy), 1);
    rst = 1'b1;
    #1;
    cmp("rs_a_busy", int'(a_busy), 0);
    cmp("rs_a_done", int'(a_done), 0);
    cmp("rs_b_busy", int'(b_busy), 0);
    en_ab = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill(ev);
    run_ab(6);
    cmp("rs_redo_done", int'(a_done), 1);
    cmp("rs_redo_pass", int'(a_pass), 1);

    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 16; k++) begin
        for (int i = 0; i < 3; i++) begin
          if ($urandom_range(0, 3) == 0) pk[k][i*8 +: 8] = 8'($urandom);
          else pk[k][i*8 +: 8] = ev[i*8 +: 8];
        end
      end
      run_ab(int'($urandom_range(1, S + C + 3)));
    end

    en_c = 1'b1;
    p_c  = 24'h06050B;
    repeat (5) @(posedge clk);
    #1;
    cmp("m_done5", int'(c_done), 0);
    @(posedge clk);
    #1;
    cmp("m_done", int'(c_done), 1);
    cmp("m_pass", int'(c_pass), 1);
    cmp("m_err",  int'(c_err),  0);
    en_c = 1'b0;
    @(posedge clk);
    #1;
    en_c = 1'b1;
    p_c  = 24'h060514;
    repeat (6) @(posedge clk);
    #1;
    cmp("m2_done", int'(c_done), 1);
    cmp("m2_err",  int'(c_err),  4);
    cmp("m2_pass", int'(c_pass), 0);
    cmp("m2_fc",   int'(c_fc),   0);
    en_c = 1'b0;

    en_d = 1'b1;
    p_d  = 8'h04;
    @(posedge clk);
    #1;
    cmp("d1_busy", int'(d_busy), 1);
    cmp("d1_done", int'(d_done), 0);
    @(posedge clk);
    #1;
    cmp("d2_done", int'(d_done), 1);
    cmp("d2_pass", int'(d_pass), 1);
    en_d = 1'b0;
    @(posedge clk);
    #1;
    en_d = 1'b1;
    p_d  = 8'h05;
    repeat (2) @(posedge clk);
    #1;
    cmp("d3_done", int'(d_done), 1);
    cmp("d3_err",  int'(d_err),  1);
    cmp("d3_pass", int'(d_pass), 0);
    cmp("d3_fc",   int'(d_fc),   0);
    cmp("d3_fy",   int'(d_fy),   0);
    en_d = 1'b0;
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
